// File: rtl/axi_byte_ram_slave.sv
// axi_byte_ram_slave
//   Byte-wide AXI slave memory. It terminates 8-bit bursts, one transaction at
//   a time. A write is AW, then W beats, then B. A read is AR, then R beats.
//   When AW and AR are requested together, the grant alternates between them.
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   s_axi_aw*                     write address channel (valid/ready/id/addr/len/size/burst)
//   s_axi_w*                      write data channel (valid/ready/data/strb/last)
//   s_axi_b*                      write response channel (valid/ready/id/resp)
//   s_axi_ar*                     read address channel (valid/ready/id/addr/len/size/burst)
//   s_axi_r*                      read data channel (valid/ready/id/data/resp/last)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no transaction; arbitrate AW against AR
// WR_DATA   | accepting W beats until beat count reaches the latched len
// WR_RESP   | presenting B; SLVERR if any beat addressed beyond DEPTH
// RD_DATA   | presenting R beats from the registered read byte
module axi_byte_ram_slave #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [ID_W-1:0]   s_axi_awid,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [7:0]        s_axi_awlen,
    input  logic [2:0]        s_axi_awsize,
    input  logic [1:0]        s_axi_awburst,

    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    input  logic [7:0]        s_axi_wdata,
    input  logic              s_axi_wstrb,
    input  logic              s_axi_wlast,

    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    output logic [ID_W-1:0]   s_axi_bid,
    output logic [1:0]        s_axi_bresp,

    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,

    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [ID_W-1:0]   s_axi_rid,
    output logic [7:0]        s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WR_DATA = 2'd1;
    localparam logic [1:0] S_WR_RESP = 2'd2;
    localparam logic [1:0] S_RD_DATA = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    logic [7:0]        mem [DEPTH];

    logic [1:0]        state;
    logic              last_was_wr;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [1:0]        burst_q;
    logic [7:0]        beat_q;
    logic              err_q;
    logic [7:0]        rdata_q;

    logic              grant_wr;
    logic              last_beat;
    logic              mem_we;
    logic [ADDR_W-1:0] addr_nxt;

    // Transfer size and WLAST carry no information for a byte-wide slave
    // whose burst length comes from AxLEN.
    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awsize, s_axi_arsize, s_axi_wlast};

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    // FIXED holds the address; INCR and WRAP both step by one byte and wrap
    // naturally at the top of the address space.
    assign addr_nxt  = (burst_q == BURST_FIXED) ? addr_q : addr_q + ADDR_W'(1);
    assign last_beat = (beat_q == len_q);

    always_comb begin
        grant_wr      = s_axi_awvalid && (!s_axi_arvalid || !last_was_wr);

        // Every output is forced quiet while rst is high, because the sync
        // reset has not yet moved the state register back to IDLE.
        s_axi_awready = !rst && (state == S_IDLE) && s_axi_awvalid && grant_wr;
        s_axi_arready = !rst && (state == S_IDLE) && s_axi_arvalid && !grant_wr;
        s_axi_wready  = !rst && (state == S_WR_DATA);
        s_axi_bvalid  = !rst && (state == S_WR_RESP);
        s_axi_rvalid  = !rst && (state == S_RD_DATA);
        s_axi_rlast   = s_axi_rvalid && last_beat;

        s_axi_bid     = rst ? '0 : id_q;
        s_axi_rid     = rst ? '0 : id_q;
        s_axi_rdata   = rst ? 8'h00 : rdata_q;
        s_axi_bresp   = (s_axi_bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
        s_axi_rresp   = (s_axi_rvalid && !in_range(addr_q)) ? RESP_SLVERR : RESP_OKAY;

        mem_we        = s_axi_wready && s_axi_wvalid && s_axi_wstrb && in_range(addr_q);
    end

    // Storage has no reset so its contents survive an aborted burst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q[IDX_W-1:0]] <= s_axi_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            last_was_wr <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= 8'd0;
            burst_q     <= 2'b00;
            beat_q      <= 8'd0;
            err_q       <= 1'b0;
            rdata_q     <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (s_axi_awready) begin
                        id_q        <= s_axi_awid;
                        addr_q      <= s_axi_awaddr;
                        len_q       <= s_axi_awlen;
                        burst_q     <= s_axi_awburst;
                        beat_q      <= 8'd0;
                        err_q       <= 1'b0;
                        last_was_wr <= 1'b1;
                        state       <= S_WR_DATA;
                    end else if (s_axi_arready) begin
                        id_q        <= s_axi_arid;
                        addr_q      <= s_axi_araddr;
                        len_q       <= s_axi_arlen;
                        burst_q     <= s_axi_arburst;
                        beat_q      <= 8'd0;
                        last_was_wr <= 1'b0;
                        // First byte is fetched now so RVALID can rise on the
                        // very next cycle with data already in place.
                        rdata_q     <= in_range(s_axi_araddr) ?
                                       mem[s_axi_araddr[IDX_W-1:0]] : 8'h00;
                        state       <= S_RD_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (s_axi_wvalid) begin
                        if (!in_range(addr_q)) begin
                            err_q <= 1'b1;
                        end
                        addr_q <= addr_nxt;
                        beat_q <= beat_q + 8'd1;
                        if (last_beat) begin
                            state <= S_WR_RESP;
                        end
                    end
                end
                S_WR_RESP: begin
                    if (s_axi_bready) begin
                        state <= S_IDLE;
                    end
                end
                S_RD_DATA: begin
                    if (s_axi_rready) begin
                        addr_q  <= addr_nxt;
                        beat_q  <= beat_q + 8'd1;
                        rdata_q <= in_range(addr_nxt) ? mem[addr_nxt[IDX_W-1:0]] : 8'h00;
                        if (last_beat) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_byte_ram_slave.sv
// tb_axi_byte_ram_slave
//   Scenario tasks drive the AXI channels. Read expectations come from a byte
//   model of the memory that the bench keeps itself. They are queued when a
//   burst is issued and compared as each R beat arrives.
module tb_axi_byte_ram_slave;

    localparam int DEPTH = 4096;

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    logic       awvalid, awready;
    logic [3:0] awid;
    logic [15:0] awaddr;
    logic [7:0] awlen;
    logic [2:0] awsize;
    logic [1:0] awburst;
    logic       wvalid, wready;
    logic [7:0] wdata;
    logic       wstrb, wlast;
    logic       bvalid, bready;
    logic [3:0] bid;
    logic [1:0] bresp;
    logic       arvalid, arready;
    logic [3:0] arid;
    logic [15:0] araddr;
    logic [7:0] arlen;
    logic [2:0] arsize;
    logic [1:0] arburst;
    logic       rvalid, rready;
    logic [3:0] rid;
    logic [7:0] rdata;
    logic [1:0] rresp;
    logic       rlast;

    axi_byte_ram_slave dut (
        .clk(clk), .rst(rst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awid(awid),
        .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
        .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bid(bid),
        .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_arid(arid),
        .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rid(rid),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] resp;
        logic       last;
        logic [3:0] id;
    } beat_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         both_cnt = 0;
    logic [7:0] model [int];
    beat_t      exp_q [$];
    logic [7:0] wd_q [$];
    logic       ws_q [$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (awready === 1'b1 && arready === 1'b1) both_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish before 500us");
        $fatal(1);
    end

    function automatic logic [15:0] adv(input logic [15:0] a, input logic [1:0] b);
        return (b == 2'b00) ? a : a + 16'd1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write burst from wd_q/ws_q; updates the model on every accepted beat.
    task automatic do_write(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int gap_pct, input int bst_pct,
                            output int aw_c, output int bv_c, output logic [1:0] br,
                            output logic [3:0] bi, output int unst, output logic wr_at_aw);
        logic [15:0] a;
        int          budget;
        int          i;
        logic        prev_stall, got_b;
        logic [1:0]  pbr;
        logic [3:0]  pbi;
        unst = 0; aw_c = -1; bv_c = -1; br = 2'b11; bi = 4'h0; wr_at_aw = 1'b1;
        prev_stall = 1'b0; got_b = 1'b0; pbr = 2'b00; pbi = 4'h0;
        awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = 3'd0; awburst = burst;
        budget = 0;
        #2;
        while (awready !== 1'b1 && budget < 50) begin step(); #2; budget++; end
        if (awready !== 1'b1) begin
            awvalid = 1'b0;
            n_tests++; n_fail++;
            $display("FAIL aw_timeout got awready=%b want 1", awready);
            return;
        end
        aw_c = cyc; wr_at_aw = wready;
        step();
        awvalid = 1'b0;
        a = addr; i = 0; budget = 0;
        while (i <= int'(len) && budget < 200) begin
            if ($urandom_range(99) < gap_pct) begin
                wvalid = 1'b0;
            end else begin
                wvalid = 1'b1; wdata = wd_q[i]; wstrb = ws_q[i]; wlast = (i == int'(len));
            end
            #2;
            if (wready !== 1'b1) unst++;
            if (wvalid && wready === 1'b1) begin
                if (ws_q[i] && int'(a) < DEPTH) model[int'(a)] = wd_q[i];
                a = adv(a, burst);
                i++;
            end
            step(); budget++;
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (i <= int'(len)) begin
            n_tests++; n_fail++;
            $display("FAIL w_timeout got %0d beats want %0d", i, int'(len) + 1);
            return;
        end
        budget = 0;
        while (budget < 100) begin
            bready = ($urandom_range(99) >= bst_pct);
            #2;
            if (bvalid === 1'b1 && bv_c < 0) bv_c = cyc;
            if (prev_stall && (bvalid !== 1'b1 || bresp !== pbr || bid !== pbi)) unst++;
            if (bvalid === 1'b1 && bready) begin
                br = bresp; bi = bid; got_b = 1'b1;
                step();
                break;
            end
            prev_stall = (bvalid === 1'b1); pbr = bresp; pbi = bid;
            step(); budget++;
        end
        bready = 1'b0;
        if (!got_b) begin
            n_tests++; n_fail++;
            $display("FAIL b_timeout got no B handshake want one");
        end
    endtask

    // Read burst; expectations are queued from the model, each R beat is
    // popped and compared as it is accepted.
    task automatic do_read(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int stall_pct,
                           output int ar_c, output int first_c, output int last_c, output int unst);
        logic [15:0] a;
        beat_t       e;
        int          budget;
        int          nb;
        logic        prev_stall;
        logic [7:0]  pd;
        logic [1:0]  pr;
        logic        pl;
        unst = 0; ar_c = -1; first_c = -1; last_c = -1; nb = 0;
        prev_stall = 1'b0; pd = 8'h00; pr = 2'b00; pl = 1'b0;
        a = addr;
        for (int k = 0; k <= int'(len); k++) begin
            e.data = (int'(a) < DEPTH) ? model[int'(a)] : 8'h00;
            e.resp = (int'(a) < DEPTH) ? 2'b00 : 2'b10;
            e.last = (k == int'(len));
            e.id   = id;
            exp_q.push_back(e);
            a = adv(a, burst);
        end
        arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = 3'd0; arburst = burst;
        budget = 0;
        #2;
        while (arready !== 1'b1 && budget < 50) begin step(); #2; budget++; end
        if (arready !== 1'b1) begin
            arvalid = 1'b0;
            n_tests++; n_fail++;
            $display("FAIL ar_timeout got arready=%b want 1", arready);
            exp_q.delete();
            return;
        end
        ar_c = cyc;
        step();
        arvalid = 1'b0;
        budget = 0;
        while (budget < 300) begin
            rready = ($urandom_range(99) >= stall_pct);
            #2;
            if (rvalid === 1'b1 && first_c < 0) first_c = cyc;
            if (prev_stall && (rvalid !== 1'b1 || rdata !== pd || rresp !== pr || rlast !== pl)) unst++;
            prev_stall = (rvalid === 1'b1) && !rready; pd = rdata; pr = rresp; pl = rlast;
            if (rvalid === 1'b1 && rready) begin
                last_c = cyc; nb++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL r_extra_beat got data=%h want no beat", rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (rdata !== e.data || rresp !== e.resp || rlast !== e.last || rid !== e.id) begin
                        n_fail++;
                        $display("FAIL r_beat%0d got data=%h resp=%b last=%b id=%h want data=%h resp=%b last=%b id=%h",
                                 nb - 1, rdata, rresp, rlast, rid, e.data, e.resp, e.last, e.id);
                    end
                end
                if (rlast === 1'b1 || nb > int'(len) + 1) begin
                    step();
                    break;
                end
            end
            step(); budget++;
        end
        rready = 1'b0;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL r_missing got %0d beats short want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        awvalid = 1'b1; arvalid = 1'b1; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        awid = 4'h0; awaddr = 16'h0; awlen = 8'd0; awsize = 3'd0; awburst = 2'b01;
        arid = 4'h0; araddr = 16'h0; arlen = 8'd0; arsize = 3'd0; arburst = 2'b01;
        wdata = 8'h00; wstrb = 1'b0; wlast = 1'b0;
        step(); step(); step();
        #2;
        n_tests++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0 || bid !== 4'h0 || rid !== 4'h0 ||
            bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_held got aw=%b ar=%b w=%b b=%b r=%b last=%b bid=%h rid=%h rdata=%h want all 0",
                     awready, arready, wready, bvalid, rvalid, rlast, bid, rid, rdata);
        end
        step();
        rst = 1'b0; awvalid = 1'b0; arvalid = 1'b0;
        #2;
        n_tests++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0 || bid !== 4'h0 || rid !== 4'h0 ||
            bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_after got aw=%b ar=%b w=%b b=%b r=%b last=%b bid=%h rid=%h rdata=%h want all 0",
                     awready, arready, wready, bvalid, rvalid, rlast, bid, rid, rdata);
        end
        step();
    endtask

    task automatic test_write_read();
        int aw_c, bv_c, unst, ar_c, f_c, l_c;
        logic [1:0] br;
        logic [3:0] bi;
        logic wa;
        wd_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        ws_q = '{1'b1, 1'b1, 1'b1, 1'b1};
        do_write(4'h5, 16'h0010, 8'd3, 2'b01, 0, 0, aw_c, bv_c, br, bi, unst, wa);
        n_tests++;
        if (bv_c - aw_c !== 5) begin n_fail++; $display("FAIL wr_b_latency got %0d want 5", bv_c - aw_c); end
        n_tests++;
        if (br !== 2'b00 || bi !== 4'h5) begin n_fail++; $display("FAIL wr_bresp got resp=%b id=%h want 00 5", br, bi); end
        n_tests++;
        if (wa !== 1'b0) begin n_fail++; $display("FAIL wready_at_aw got %b want 0", wa); end
        do_read(4'h9, 16'h0010, 8'd3, 2'b01, 0, ar_c, f_c, l_c, unst);
        n_tests++;
        if (f_c - ar_c !== 1) begin n_fail++; $display("FAIL rd_first_latency got %0d want 1", f_c - ar_c); end
        n_tests++;
        if (l_c - ar_c !== 4) begin n_fail++; $display("FAIL rd_last_latency got %0d want 4", l_c - ar_c); end
    endtask

    task automatic test_arbitration();
        int ar_c, f_c, l_c, unst;
        awvalid = 1'b1; awid = 4'h1; awaddr = 16'h0040; awlen = 8'd0; awburst = 2'b01;
        arvalid = 1'b1; arid = 4'h2; araddr = 16'h0010; arlen = 8'd0; arburst = 2'b01;
        #2;
        n_tests++;
        if (awready !== 1'b1 || arready !== 1'b0) begin
            n_fail++; $display("FAIL tie1 got awready=%b arready=%b want 1 0", awready, arready);
        end
        step();
        awvalid = 1'b0; wvalid = 1'b1; wdata = 8'h5A; wstrb = 1'b1; wlast = 1'b1; bready = 1'b1;
        #2;
        n_tests++;
        if (arready !== 1'b0 || wready !== 1'b1) begin
            n_fail++; $display("FAIL busy_wr got arready=%b wready=%b want 0 1", arready, wready);
        end
        step();
        wvalid = 1'b0; wlast = 1'b0; model[16'h40] = 8'h5A;
        #2;
        n_tests++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || bid !== 4'h1) begin
            n_fail++; $display("FAIL tie1_b got bvalid=%b resp=%b id=%h want 1 00 1", bvalid, bresp, bid);
        end
        step();
        awvalid = 1'b1; awid = 4'h3; awaddr = 16'h0041;
        #2;
        n_tests++;
        if (arready !== 1'b1 || awready !== 1'b0) begin
            n_fail++; $display("FAIL tie2 got awready=%b arready=%b want 0 1", awready, arready);
        end
        step();
        arvalid = 1'b0; rready = 1'b1;
        #2;
        n_tests++;
        if (rvalid !== 1'b1 || rdata !== 8'h11 || rlast !== 1'b1 || rid !== 4'h2) begin
            n_fail++; $display("FAIL tie2_r got rvalid=%b data=%h last=%b id=%h want 1 11 1 2", rvalid, rdata, rlast, rid);
        end
        step();
        rready = 1'b0; arvalid = 1'b1; araddr = 16'h0040;
        #2;
        n_tests++;
        if (awready !== 1'b1 || arready !== 1'b0) begin
            n_fail++; $display("FAIL tie3 got awready=%b arready=%b want 1 0", awready, arready);
        end
        step();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b1; wdata = 8'h5B; wstrb = 1'b1; wlast = 1'b1; bready = 1'b1;
        step();
        wvalid = 1'b0; wlast = 1'b0; model[16'h41] = 8'h5B;
        #2;
        n_tests++;
        if (bvalid !== 1'b1 || bid !== 4'h3) begin
            n_fail++; $display("FAIL tie3_b got bvalid=%b id=%h want 1 3", bvalid, bid);
        end
        step();
        bready = 1'b0;
        do_read(4'h4, 16'h0040, 8'd1, 2'b01, 0, ar_c, f_c, l_c, unst);
        n_tests++;
        if (both_cnt !== 0) begin n_fail++; $display("FAIL both_ready got %0d cycles want 0", both_cnt); end
    endtask

    task automatic test_out_of_range();
        int aw_c, bv_c, unst, ar_c, f_c, l_c;
        logic [1:0] br;
        logic [3:0] bi;
        logic wa;
        wd_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        ws_q = '{1'b1, 1'b1, 1'b1, 1'b1};
        do_write(4'h6, 16'h0FFE, 8'd3, 2'b01, 0, 0, aw_c, bv_c, br, bi, unst, wa);
        n_tests++;
        if (br !== 2'b10 || bi !== 4'h6) begin n_fail++; $display("FAIL oor_bresp got resp=%b id=%h want 10 6", br, bi); end
        do_read(4'h7, 16'h0FFE, 8'd3, 2'b01, 0, ar_c, f_c, l_c, unst);
    endtask

    task automatic test_backpressure();
        int aw_c, bv_c, unst, ar_c, f_c, l_c;
        logic [1:0] br;
        logic [3:0] bi;
        logic wa;
        logic [15:0] base;
        for (int it = 0; it < 3; it++) begin
            base = 16'h0100 + 16'(it * 16);
            wd_q.delete(); ws_q.delete();
            for (int k = 0; k < 4; k++) begin wd_q.push_back(8'($urandom)); ws_q.push_back(1'b1); end
            do_write(4'(it + 8), base, 8'd3, 2'b01, 40, 50, aw_c, bv_c, br, bi, unst, wa);
            n_tests++;
            if (br !== 2'b00 || bi !== 4'(it + 8) || unst !== 0) begin
                n_fail++; $display("FAIL bp_write%0d got resp=%b id=%h unstable=%0d want 00 %h 0", it, br, bi, unst, 4'(it + 8));
            end
            do_read(4'(it + 1), base, 8'd3, 2'b01, 50, ar_c, f_c, l_c, unst);
            n_tests++;
            if (unst !== 0) begin n_fail++; $display("FAIL bp_read%0d got unstable=%0d want 0", it, unst); end
        end
    endtask

    task automatic test_fixed_strb();
        int aw_c, bv_c, unst, ar_c, f_c, l_c;
        logic [1:0] br;
        logic [3:0] bi;
        logic wa;
        wd_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        ws_q = '{1'b1, 1'b1, 1'b1, 1'b1};
        do_write(4'h8, 16'h0020, 8'd3, 2'b00, 0, 0, aw_c, bv_c, br, bi, unst, wa);
        n_tests++;
        if (br !== 2'b00) begin n_fail++; $display("FAIL fixed_bresp got %b want 00", br); end
        do_read(4'h8, 16'h0020, 8'd2, 2'b00, 0, ar_c, f_c, l_c, unst);
        do_read(4'h8, 16'h0020, 8'd1, 2'b01, 0, ar_c, f_c, l_c, unst);
        wd_q = '{8'h77, 8'h66};
        ws_q = '{1'b1, 1'b1};
        do_write(4'hA, 16'h0030, 8'd1, 2'b01, 0, 0, aw_c, bv_c, br, bi, unst, wa);
        wd_q = '{8'h99, 8'h88};
        ws_q = '{1'b1, 1'b0};
        do_write(4'hA, 16'h0030, 8'd1, 2'b01, 0, 0, aw_c, bv_c, br, bi, unst, wa);
        do_read(4'hB, 16'h0030, 8'd1, 2'b01, 0, ar_c, f_c, l_c, unst);
    endtask

    task automatic test_reset_mid_burst();
        int ar_c, f_c, l_c, unst;
        awvalid = 1'b1; awid = 4'h3; awaddr = 16'h0050; awlen = 8'd3; awburst = 2'b01;
        #2;
        n_tests++;
        if (awready !== 1'b1) begin n_fail++; $display("FAIL mid_aw got awready=%b want 1", awready); end
        step();
        awvalid = 1'b0; wvalid = 1'b1; wdata = 8'hE1; wstrb = 1'b1; wlast = 1'b0;
        step();
        model[16'h50] = 8'hE1;
        wdata = 8'hE2; rst = 1'b1;
        step();
        rst = 1'b0; wvalid = 1'b0;
        awvalid = 1'b1; awid = 4'h4; awaddr = 16'h0060; awlen = 8'd0;
        #2;
        n_tests++;
        if (bvalid !== 1'b0 || wready !== 1'b0 || rvalid !== 1'b0 || awready !== 1'b1) begin
            n_fail++; $display("FAIL mid_rst_idle got b=%b w=%b r=%b aw=%b want 0 0 0 1", bvalid, wready, rvalid, awready);
        end
        step();
        awvalid = 1'b0; wvalid = 1'b1; wdata = 8'hE7; wstrb = 1'b1; wlast = 1'b1; bready = 1'b1;
        step();
        wvalid = 1'b0; wlast = 1'b0; model[16'h60] = 8'hE7;
        #2;
        n_tests++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || bid !== 4'h4) begin
            n_fail++; $display("FAIL mid_new_b got bvalid=%b resp=%b id=%h want 1 00 4", bvalid, bresp, bid);
        end
        step();
        bready = 1'b0;
        do_read(4'h3, 16'h0050, 8'd0, 2'b01, 0, ar_c, f_c, l_c, unst);
        do_read(4'h4, 16'h0060, 8'd0, 2'b01, 0, ar_c, f_c, l_c, unst);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_arbitration();
        test_out_of_range();
        test_backpressure();
        test_fixed_strb();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
